// File: rtl/invader_formation_move_if.sv
// Control and status bundle for the invader formation mover.
// The master side paces frames and issues commands; the slave side reports the formation position.
interface invader_formation_move_if #(
  parameter int MAX_LEVEL = 7
);
  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);

  logic               startOfFrame;
  logic               start;
  logic               speedUp;
  logic               pause;
  logic               chgDir;
  logic [10:0]        topLeftX;
  logic [10:0]        topLeftY;
  logic [LEVEL_W-1:0] level;
  logic               moving;
  logic               edgeHit;
  logic               landed;

  modport master (
    output startOfFrame, start, speedUp, pause, chgDir,
    input  topLeftX, topLeftY, level, moving, edgeHit, landed
  );

  modport slave (
    input  startOfFrame, start, speedUp, pause, chgDir,
    output topLeftX, topLeftY, level, moving, edgeHit, landed
  );
endinterface

// File: rtl/invader_formation_move.sv
// Space-invader formation motion: sweeps right and left in fixed point, drops one row at each edge,
// and stops for good once the formation reaches the bottom line.
module invader_formation_move #(
  parameter int INIT_X       = 20,
  parameter int INIT_Y       = 20,
  parameter int FRAC_BITS    = 6,
  parameter int X_STEP       = 80,
  parameter int X_STEP_INC   = 16,
  parameter int MAX_LEVEL    = 7,
  parameter int Y_STEP       = 64,
  parameter int DESC_PX      = 16,
  parameter int LEFT_LIMIT   = 0,
  parameter int RIGHT_LIMIT  = 439,
  parameter int BOTTOM_LIMIT = 400
) (
  input logic                     clk,
  input logic                     reset,
  invader_formation_move_if.slave bus
);

  localparam int ACC_W   = 11 + FRAC_BITS;
  localparam int SUM_W   = ACC_W + 1;
  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);

  localparam logic [ACC_W-1:0]   X_INIT_ACC = ACC_W'(INIT_X) << FRAC_BITS;
  localparam logic [ACC_W-1:0]   Y_INIT_ACC = ACC_W'(INIT_Y) << FRAC_BITS;
  localparam logic [ACC_W-1:0]   LEFT_ACC   = ACC_W'(LEFT_LIMIT) << FRAC_BITS;
  localparam logic [ACC_W-1:0]   RIGHT_ACC  = ACC_W'(RIGHT_LIMIT) << FRAC_BITS;
  localparam logic [ACC_W-1:0]   BOTTOM_ACC = ACC_W'(BOTTOM_LIMIT) << FRAC_BITS;
  localparam logic [ACC_W-1:0]   DESC_ACC   = ACC_W'(DESC_PX) << FRAC_BITS;
  localparam logic [SUM_W-1:0]   Y_STEP_W   = SUM_W'(Y_STEP);
  localparam logic [SUM_W-1:0]   X_BASE_W   = SUM_W'(X_STEP);
  localparam logic [SUM_W-1:0]   X_INC_W    = SUM_W'(X_STEP_INC);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    IDLE,
    MOV_RGT,
    DESC_L,
    MOV_LFT,
    DESC_R,
    LANDED
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   xAcc_q, xAcc_d;
  logic [ACC_W-1:0]   yAcc_q, yAcc_d;
  logic [ACC_W-1:0]   target_q, target_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               edgeHit_q, edgeHit_d;
  logic               moving_q;
  logic               landed_q;

  logic               frame;
  logic [SUM_W-1:0]   speed;
  logic [SUM_W-1:0]   xRight;
  logic [ACC_W-1:0]   xLeft;
  logic               hitRight;
  logic               hitLeft;
  logic [SUM_W-1:0]   yDown;
  logic [ACC_W-1:0]   yNext;

  assign frame = bus.startOfFrame & ~bus.pause;

  // Speed comes from the registered level, so a same-cycle speedUp only affects later frames.
  assign speed    = X_BASE_W + SUM_W'(level_q) * X_INC_W;
  assign xRight   = {1'b0, xAcc_q} + speed;
  assign hitRight = (xRight >= {1'b0, RIGHT_ACC});

  // Compare before subtracting so the left sweep never wraps below zero.
  assign hitLeft  = ({1'b0, xAcc_q} <= ({1'b0, LEFT_ACC} + speed));
  assign xLeft    = xAcc_q - speed[ACC_W-1:0];

  assign yDown    = {1'b0, yAcc_q} + Y_STEP_W;
  assign yNext    = (yDown >= {1'b0, target_q}) ? target_q : yDown[ACC_W-1:0];

  always_comb begin
    state_d   = state_q;
    xAcc_d    = xAcc_q;
    yAcc_d    = yAcc_q;
    target_d  = target_q;
    level_d   = level_q;
    edgeHit_d = 1'b0;

    if (bus.speedUp && (state_q != LANDED) && (level_q != LEVEL_MAX)) begin
      level_d = level_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = MOV_RGT;
        end
      end

      // A forced direction change takes precedence and suppresses that cycle's step,
      // so a coincident limit hit still yields a single descent.
      MOV_RGT: begin
        if (bus.chgDir || (frame && hitRight)) begin
          if (!bus.chgDir) begin
            xAcc_d = RIGHT_ACC;
          end
          state_d   = DESC_L;
          target_d  = yAcc_q + DESC_ACC;
          edgeHit_d = 1'b1;
        end else if (frame) begin
          xAcc_d = xRight[ACC_W-1:0];
        end
      end

      MOV_LFT: begin
        if (bus.chgDir || (frame && hitLeft)) begin
          if (!bus.chgDir) begin
            xAcc_d = LEFT_ACC;
          end
          state_d   = DESC_R;
          target_d  = yAcc_q + DESC_ACC;
          edgeHit_d = 1'b1;
        end else if (frame) begin
          xAcc_d = xLeft;
        end
      end

      DESC_L, DESC_R: begin
        if (frame) begin
          if (yNext >= BOTTOM_ACC) begin
            yAcc_d  = BOTTOM_ACC;
            state_d = LANDED;
          end else begin
            yAcc_d = yNext;
            if (yNext == target_q) begin
              state_d = (state_q == DESC_L) ? MOV_LFT : MOV_RGT;
            end
          end
        end
      end

      LANDED: begin
        state_d = LANDED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are derived from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      xAcc_q    <= X_INIT_ACC;
      yAcc_q    <= Y_INIT_ACC;
      target_q  <= '0;
      level_q   <= '0;
      edgeHit_q <= 1'b0;
      moving_q  <= 1'b0;
      landed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      xAcc_q    <= xAcc_d;
      yAcc_q    <= yAcc_d;
      target_q  <= target_d;
      level_q   <= level_d;
      edgeHit_q <= edgeHit_d;
      moving_q  <= (state_d inside {MOV_RGT, MOV_LFT, DESC_L, DESC_R});
      landed_q  <= (state_d == LANDED);
    end
  end

  assign bus.topLeftX = xAcc_q[ACC_W-1:FRAC_BITS];
  assign bus.topLeftY = yAcc_q[ACC_W-1:FRAC_BITS];
  assign bus.level    = level_q;
  assign bus.moving   = moving_q;
  assign bus.edgeHit  = edgeHit_q;
  assign bus.landed   = landed_q;

endmodule

// File: doc/invader_formation_move.md
INVADER_FORMATION_MOVE -- requirements
Module: invader_formation_move

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- INIT_X, 20, reset topLeftX in pixels.
- INIT_Y, 20, reset topLeftY in pixels.
- FRAC_BITS, 6, fractional bits of the position accumulators.
- X_STEP, 80, horizontal step per frame at level 0, in 1/2^FRAC_BITS px.
- X_STEP_INC, 16, added horizontal step per speed level.
- MAX_LEVEL, 7, saturation value of the speed level.
- Y_STEP, 64, vertical step per frame while descending, in 1/2^FRAC_BITS px.
- DESC_PX, 16, pixels descended per edge event.
- LEFT_LIMIT, 0, minimum topLeftX in pixels.
- RIGHT_LIMIT, 439, maximum topLeftX in pixels.
- BOTTOM_LIMIT, 400, topLeftY value that ends the game.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-high.
- startOfFrame, in, 1, one-cycle pulse per frame.
- start, in, 1, pulse that leaves IDLE.
- speedUp, in, 1, pulse that raises the speed level by one.
- pause, in, 1, level; freezes motion while high.
- chgDir, in, 1, pulse that forces an early edge event.
- topLeftX, out, 11, integer pixel X.
- topLeftY, out, 11, integer pixel Y.
- level, out, $clog2(MAX_LEVEL+1), current speed level.
- moving, out, 1, high in the MOV_RGT, MOV_LFT, DESC_L and DESC_R states.
- edgeHit, out, 1, one-cycle pulse on entry to DESC_L or DESC_R.
- landed, out, 1, high in LANDED.

Function
REQ-003 The FSM states SHALL be IDLE, MOV_RGT, DESC_L, MOV_LFT, DESC_R and LANDED; all state and position registers update on posedge clk.
REQ-004 IDLE->MOV_RGT SHALL occur on start; start SHALL be ignored in every other state.
REQ-005 Position SHALL be held as unsigned fixed point with 11+FRAC_BITS bits per axis; topLeftX and topLeftY SHALL be the accumulators shifted right by FRAC_BITS (truncation).
REQ-006 Horizontal speed SHALL be X_STEP + level*X_STEP_INC.
REQ-007 Accumulators SHALL change only on a cycle with startOfFrame=1 and pause=0, and only in MOV_RGT, MOV_LFT, DESC_L or DESC_R.
REQ-008 In MOV_RGT, X SHALL become min(X+speed, RIGHT_LIMIT<<FRAC_BITS); when the clamped result equals the limit, the next state SHALL be DESC_L.
REQ-009 In MOV_LFT, X SHALL become max(X-speed, LEFT_LIMIT<<FRAC_BITS); when the clamped result equals the limit, the next state SHALL be DESC_R. No underflow shall occur.
REQ-010 On entry to DESC_L or DESC_R, a target register SHALL latch Y+(DESC_PX<<FRAC_BITS).
REQ-011 During a descent, each qualified frame SHALL set Y=min(Y+Y_STEP, target). On reaching the target, DESC_L SHALL go to MOV_LFT and DESC_R SHALL go to MOV_RGT.
REQ-012 If Y>=BOTTOM_LIMIT<<FRAC_BITS after any descent update, the next state SHALL be LANDED with Y clamped to BOTTOM_LIMIT; LANDED SHALL be held until reset.
REQ-013 chgDir in MOV_RGT SHALL enter DESC_L, and chgDir in MOV_LFT SHALL enter DESC_R, on the next cycle with no position change that cycle. chgDir SHALL be ignored in all other states.
REQ-014 If chgDir and a limit hit occur in the same cycle, exactly one descent and one edgeHit pulse SHALL result.
REQ-015 speedUp SHALL increment level, saturating at MAX_LEVEL, in any state except LANDED, including while paused.
REQ-016 If speedUp and a qualified frame occur in the same cycle, the frame SHALL use the old level.
REQ-017 pause SHALL freeze the state and position. start, chgDir and speedUp SHALL still act while paused.

Reset
REQ-018 While reset=1 (asynchronous assert), the outputs SHALL be: state IDLE, topLeftX=INIT_X, topLeftY=INIT_Y, level=0, moving=0, edgeHit=0, landed=0. Descent target=0.
REQ-019 Reset asserted mid-descent or in LANDED SHALL return the block to the REQ-018 values on the same edge; operation SHALL resume only after reset=0 and a new start.

Verification
REQ-020 Reset, then start, then frames at level 0 -> topLeftX reaches 439 exactly at frame 336; edgeHit pulses once; 16 further frames bring topLeftY 20->36; the block then enters MOV_LFT.
REQ-021 Pulse speedUp 9 times -> level saturates at 7; the per-frame X delta is 3 px (192/64).
REQ-022 Pulse chgDir at frame 10 of MOV_RGT -> DESC_L is entered with topLeftX=32; topLeftY advances 16 px; the block enters MOV_LFT. A chgDir pulse during DESC_L has no effect.
REQ-023 Hold pause for 50 frames mid-MOV_LFT -> topLeftX/Y remain unchanged; a speedUp pulse during the pause takes level to 1; motion resumes at 1.5 px/frame.
REQ-024 With BOTTOM_LIMIT=36, run to the first descent end -> landed=1, topLeftY=36, moving=0; subsequent frames and speedUp pulses have no effect.
REQ-025 Assert reset during DESC_R -> all outputs equal the REQ-018 values immediately; start restarts motion from X=20.
